// File: rtl/button_sim_pkg.sv
// Shared types and constants for the button-press stimulus generator:
// the sequencer state encoding, the LFSR feedback mask and default seed,
// and a single-step helper for the 16-bit Galois LFSR.
package button_sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_BOUNCE,
        HOLD,
        RELEASE_BOUNCE,
        GAP
    } state_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only when asked, so the pseudorandom
// sequence is consumed exactly once per bounce edge.
module lfsr16
    import button_sim_pkg::*;
#(
    parameter logic [15:0] seed = LFSR_DEFAULT_SEED
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    // Hold the seed in reset, advance one step on each request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/button_press_gen.sv
// Button-press stimulus generator. On a start request it emits an active-low
// waveform: press bounce, settled hold, release bounce, quiet gap, and then
// pulses done and bumps its own press counter.
// Build option BOUNCE_LFSR_EN: when defined, each bounce level lasts a
// pseudorandom 1..2^BOUNCE_W cycles drawn from an lfsr16 instance; when not
// defined, every level lasts 2^(BOUNCE_W-1) cycles and no LFSR exists.
module button_press_gen
    import button_sim_pkg::*;
#(
    parameter int unsigned BOUNCE_TOGGLES = 7,
    parameter int unsigned BOUNCE_W       = 8,
    parameter logic [23:0] HOLD_CYC       = 24'd600000,
    parameter logic [23:0] GAP_CYC        = 24'd240000,
    parameter logic [15:0] LFSR_SEED      = LFSR_DEFAULT_SEED
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       btn_n,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_count
);

    localparam int unsigned IVL_W     = BOUNCE_W + 1;
    localparam int unsigned EDGE_W    = $clog2(BOUNCE_TOGGLES + 1);
    localparam int unsigned FIXED_IVL = 1 << (BOUNCE_W - 1);

    state_t              state_q, state_d;
    logic                btn_q, btn_d;
    logic                done_q, done_d;
    logic [7:0]          count_q, count_d;
    logic [IVL_W-1:0]    ivl_q, ivl_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic [23:0]         hold_q, hold_d;
    logic [IVL_W-1:0]    ivl_load;
    logic                lfsr_adv;

`ifdef BOUNCE_LFSR_EN
    logic [15:0] lfsr_q;
    logic        unused_lfsr_bits;

    lfsr16 #(.seed(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (lfsr_adv),
        .q   (lfsr_q)
    );

    assign ivl_load         = {1'b0, lfsr_q[BOUNCE_W-1:0]} + IVL_W'(1);
    assign unused_lfsr_bits = ^lfsr_q;
`else
    logic unused_lfsr_adv;

    assign ivl_load        = IVL_W'(FIXED_IVL);
    assign unused_lfsr_adv = lfsr_adv;
`endif

    assign btn_n       = btn_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign press_count = count_q;

    // State and waveform registers; reset forces the button line released at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            btn_q   <= 1'b1;
            done_q  <= 1'b0;
            count_q <= 8'd0;
            ivl_q   <= '0;
            edge_q  <= '0;
            hold_q  <= 24'd0;
        end else begin
            state_q <= state_d;
            btn_q   <= btn_d;
            done_q  <= done_d;
            count_q <= count_d;
            ivl_q   <= ivl_d;
            edge_q  <= edge_d;
            hold_q  <= hold_d;
        end
    end

    // Sequencer: each edge loads a fresh interval; abort overrides everything while busy
    always_comb begin
        state_d  = state_q;
        btn_d    = btn_q;
        done_d   = 1'b0;
        count_d  = count_q;
        ivl_d    = ivl_q;
        edge_d   = edge_q;
        hold_d   = hold_q;
        lfsr_adv = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = PRESS_BOUNCE;
                    btn_d    = 1'b0;
                    edge_d   = EDGE_W'(1);
                    ivl_d    = ivl_load;
                    lfsr_adv = 1'b1;
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (ivl_q <= IVL_W'(1)) begin
                    if (edge_q < EDGE_W'(BOUNCE_TOGGLES)) begin
                        btn_d    = ~btn_q;
                        edge_d   = edge_q + EDGE_W'(1);
                        ivl_d    = ivl_load;
                        lfsr_adv = 1'b1;
                    end else begin
                        state_d = (state_q == PRESS_BOUNCE) ? HOLD : GAP;
                        hold_d  = (state_q == PRESS_BOUNCE) ? HOLD_CYC : GAP_CYC;
                        ivl_d   = '0;
                        edge_d  = '0;
                    end
                end else begin
                    ivl_d = ivl_q - IVL_W'(1);
                end
            end
            HOLD: begin
                if (hold_q <= 24'd1) begin
                    state_d  = RELEASE_BOUNCE;
                    btn_d    = 1'b1;
                    edge_d   = EDGE_W'(1);
                    ivl_d    = ivl_load;
                    lfsr_adv = 1'b1;
                    hold_d   = 24'd0;
                end else begin
                    hold_d = hold_q - 24'd1;
                end
            end
            GAP: begin
                if (hold_q <= 24'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    count_d = count_q + 8'd1;
                    hold_d  = 24'd0;
                end else begin
                    hold_d = hold_q - 24'd1;
                end
            end
            default: begin
                state_d = IDLE;
                btn_d   = 1'b1;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            btn_d    = 1'b1;
            done_d   = 1'b0;
            count_d  = count_q;
            ivl_d    = '0;
            edge_d   = '0;
            hold_d   = 24'd0;
            lfsr_adv = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_press_gen.sv
// Directed testbench for button_press_gen with BOUNCE_TOGGLES=3, BOUNCE_W=2,
// HOLD_CYC=20, GAP_CYC=10. Without BOUNCE_LFSR_EN every bounce level is 2
// cycles; with it, intervals follow the LFSR sequence from seed 16'hACE1.
module tb_button_press_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       btn_n;
    logic       busy;
    logic       done;
    logic [7:0] press_count;

    int checks = 0;
    int errors = 0;

    button_press_gen #(
        .BOUNCE_TOGGLES (3),
        .BOUNCE_W       (2),
        .HOLD_CYC       (24'd20),
        .GAP_CYC        (24'd10),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .btn_n       (btn_n),
        .busy        (busy),
        .done        (done),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge, where outputs are stable
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Hand-derived waveform for I=2: cycle 1 is the cycle after start is sampled
    function automatic logic exp_btn(input int c);
        if (c >= 1 && c <= 2)   return 1'b0;
        if (c >= 3 && c <= 4)   return 1'b1;
        if (c >= 5 && c <= 26)  return 1'b0;
        if (c >= 27 && c <= 28) return 1'b1;
        if (c >= 29 && c <= 30) return 1'b0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (btn_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || press_count !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: got btn_n=%b busy=%b done=%b count=%0d, want 1 0 0 0",
                         i, btn_n, busy, done, press_count);
            end
        end
    endtask

    task automatic test_single_press();
        logic [7:0] base;
        base = press_count;
        checks++;
        if (btn_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_pre: got btn_n=%b busy=%b, want 1 0", btn_n, busy);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            checks++;
            if (btn_n !== exp_btn(c)) begin
                errors++;
                $display("[TB] FAIL single_btn cycle %0d: got %b, want %b", c, btn_n, exp_btn(c));
            end
            checks++;
            if (busy !== (c <= 42)) begin
                errors++;
                $display("[TB] FAIL single_busy cycle %0d: got %b, want %b", c, busy, (c <= 42));
            end
            checks++;
            if (done !== (c == 43)) begin
                errors++;
                $display("[TB] FAIL single_done cycle %0d: got %b, want %b", c, done, (c == 43));
            end
            if (c == 43) begin
                checks++;
                if (press_count !== base + 8'd1) begin
                    errors++;
                    $display("[TB] FAIL single_count: got %0d, want %0d", press_count, base + 8'd1);
                end
            end
            if (c == 20) start = 1'b1;
            if (c == 21) start = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        logic       prev_busy;
        int         rises;
        int         dones;
        base      = press_count;
        prev_busy = 1'b0;
        rises     = 0;
        dones     = 0;
        start     = 1'b1;
        step();
        for (int c = 1; c <= 130; c++) begin
            if (busy === 1'b1 && prev_busy === 1'b0) begin
                rises++;
                checks++;
                if (btn_n !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_first_low cycle %0d: got btn_n=%b, want 0", c, btn_n);
                end
            end
            if (done === 1'b1) dones++;
            checks++;
            if (busy !== !(c == 43 || c == 86 || c >= 129)) begin
                errors++;
                $display("[TB] FAIL b2b_busy cycle %0d: got %b, want %b", c, busy, !(c == 43 || c == 86 || c >= 129));
            end
            checks++;
            if (done !== (c == 43 || c == 86 || c == 129)) begin
                errors++;
                $display("[TB] FAIL b2b_done cycle %0d: got %b, want %b", c, done, (c == 43 || c == 86 || c == 129));
            end
            if (c == 129) begin
                checks++;
                if (press_count !== base + 8'd3) begin
                    errors++;
                    $display("[TB] FAIL b2b_count: got %0d, want %0d", press_count, base + 8'd3);
                end
                start = 1'b0;
            end
            prev_busy = busy;
            step();
        end
        checks++;
        if (rises != 3 || dones != 3) begin
            errors++;
            $display("[TB] FAIL b2b_presses: got rises=%0d dones=%0d, want 3 3", rises, dones);
        end
    endtask

`ifdef BOUNCE_LFSR_EN
    logic [63:0] trace_a;
    logic [63:0] trace_b;

    task automatic capture_run(input int which);
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (which == 0) trace_a[i] = btn_n;
            else            trace_b[i] = btn_n;
            step();
        end
    endtask

    task automatic test_lfsr_intervals();
        int runs[$];
        int len;
        int exp_runs[5];
        exp_runs = '{2, 1, 21, 1, 3};
        capture_run(0);
        len = 1;
        for (int i = 1; i < 64; i++) begin
            if (trace_a[i] === trace_a[i-1]) begin
                len++;
            end else begin
                runs.push_back(len);
                len = 1;
            end
        end
        runs.push_back(len);
        checks++;
        if (runs.size() < 6 || trace_a[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lfsr_shape: got %0d runs first=%b, want >=6 runs first=0", runs.size(), trace_a[0]);
        end else begin
            for (int r = 0; r < 5; r++) begin
                checks++;
                if (runs[r] != exp_runs[r]) begin
                    errors++;
                    $display("[TB] FAIL lfsr_run%0d: got %0d cycles, want %0d", r, runs[r], exp_runs[r]);
                end
                if (r != 2) begin
                    checks++;
                    if (runs[r] < 1 || runs[r] > 4) begin
                        errors++;
                        $display("[TB] FAIL lfsr_range%0d: got %0d, want 1..4", r, runs[r]);
                    end
                end
            end
        end
        capture_run(1);
        checks++;
        if (trace_a !== trace_b) begin
            errors++;
            $display("[TB] FAIL lfsr_repeat: got %h, want %h", trace_b, trace_a);
        end
    endtask
`endif

    task automatic test_abort();
        logic [7:0] base;
        int         stray;
        base  = press_count;
        stray = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        checks++;
        if (busy !== 1'b1 || btn_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_pre cycle 15: got busy=%b btn_n=%b, want 1 0", busy, btn_n);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (btn_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_next: got btn_n=%b busy=%b done=%b, want 1 0 0", btn_n, busy, done);
        end
        for (int i = 0; i < 50; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) stray++;
            step();
        end
        checks++;
        if (stray != 0 || press_count !== base) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got stray=%0d count=%0d, want 0 %0d", stray, press_count, base);
        end
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy !== 1'b0 || btn_n !== 1'b1) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("[TB] FAIL abort_start_same: got %0d active cycles, want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
`ifndef BOUNCE_LFSR_EN
        checks++;
        if (btn_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_pre: got btn_n=%b, want 0", btn_n);
        end
`endif
        rst = 1'b1;
        #1;
        checks++;
        if (btn_n !== 1'b1 || busy !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got btn_n=%b busy=%b count=%0d, want 1 0 0", btn_n, busy, press_count);
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (btn_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || press_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rstmid_after: got btn_n=%b busy=%b done=%b count=%0d, want 1 0 0 0",
                     btn_n, busy, done, press_count);
        end
    endtask

    task automatic test_wrap();
        int  waited;
        for (int p = 1; p <= 256; p++) begin
            start = 1'b1;
            step();
            start = 1'b0;
            waited = 0;
            while (done !== 1'b1 && waited < 200) begin
                step();
                waited++;
            end
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL wrap_timeout press %0d: got no done in 200 cycles, want done", p);
                break;
            end
            if (p == 255) begin
                checks++;
                if (press_count !== 8'd255) begin
                    errors++;
                    $display("[TB] FAIL wrap_255: got %0d, want 255", press_count);
                end
            end
            if (p == 256) begin
                checks++;
                if (press_count !== 8'd0) begin
                    errors++;
                    $display("[TB] FAIL wrap_0: got %0d, want 0", press_count);
                end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        test_reset();
`ifdef BOUNCE_LFSR_EN
        test_lfsr_intervals();
`else
        test_single_press();
        test_back_to_back();
`endif
        test_abort();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
